// File: rtl/hs_pkg.sv
// Shared types for the hiscore save scheduler: FSM state encoding, counter width
// and a saturating increment helper.
package hs_pkg;

    localparam int HS_CNT_W = 24;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        CLEAN    = 3'd1,
        DIRTY    = 3'd2,
        SAVING   = 3'd3,
        HOLDOFF  = 3'd4
    } hs_save_state_e;

    function automatic logic [HS_CNT_W-1:0] sat_inc(input logic [HS_CNT_W-1:0] v);
        return (v == {HS_CNT_W{1'b1}}) ? v : v + HS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hs_window_hit.sv
// Combinational detector for CPU writes landing inside the hiscore RAM window.
module hs_window_hit
    import hs_pkg::*;
#(
    parameter logic [11:0] WIN_BASE = 12'h620,
    parameter logic [11:0] WIN_LEN  = 12'h050
) (
    input  logic        i_wr,
    input  logic [11:0] i_addr,
    output logic        o_hit
);

    logic [12:0] w_addr;
    logic [12:0] w_lo;
    logic [12:0] w_hi;

    // 13-bit compare so a window ending at 0x1000 does not wrap to zero
    assign w_addr = {1'b0, i_addr};
    assign w_lo   = {1'b0, WIN_BASE};
    assign w_hi   = {1'b0, WIN_BASE} + {1'b0, WIN_LEN};
    assign o_hit  = i_wr && (w_addr >= w_lo) && (w_addr < w_hi);

endmodule

// File: rtl/hs_save_scheduler.sv
// Schedules hiscore dataslot saves after the window has been quiet for a while.
// Define HS_SAVE_HALT_EN to drive processor_halt while a save is in flight.
module hs_save_scheduler
    import hs_pkg::*;
#(
    parameter logic [15:0] SLOT_ID        = 16'd2,
    parameter logic [31:0] BRIDGE_ADDR    = 32'h10001620,
    parameter logic [11:0] WIN_BASE       = 12'h620,
    parameter logic [11:0] WIN_LEN        = 12'h050,
    parameter logic [23:0] QUIET_CYCLES   = 24'd1_000_000,
    parameter logic [23:0] HOLDOFF_CYCLES = 24'd4_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic        cpu_wr,
    input  logic [11:0] cpu_addr,
    output logic        save_valid,
    output logic [15:0] save_slot_id,
    output logic [31:0] save_bridge_addr,
    output logic [31:0] save_length,
    input  logic        save_done,
    output logic        dirty,
    output logic [7:0]  save_count,
    output logic        timeout_err,
    output logic        processor_halt
);

    localparam logic [HS_CNT_W-1:0] QUIET_LAST = QUIET_CYCLES - 24'd1;
    localparam logic [HS_CNT_W-1:0] HOLD_LAST  = HOLDOFF_CYCLES - 24'd1;
    localparam logic [HS_CNT_W-1:0] TMO_LAST   = TIMEOUT_CYCLES - 24'd1;

    hs_save_state_e      r_state;
    hs_save_state_e      w_state_nxt;
    logic [HS_CNT_W-1:0] r_cnt;
    logic [HS_CNT_W-1:0] w_cnt_nxt;
    logic                r_pending;
    logic                w_pend_nxt;
    logic [7:0]          r_save_count;
    logic [7:0]          w_count_nxt;
    logic                r_timeout_err;
    logic                w_terr_nxt;
    logic                r_valid;
    logic                r_dirty;
    logic                r_halt;
    logic                w_hit;

    hs_window_hit #(
        .WIN_BASE (WIN_BASE),
        .WIN_LEN  (WIN_LEN)
    ) u_hit (
        .i_wr   (cpu_wr),
        .i_addr (cpu_addr),
        .o_hit  (w_hit)
    );

    // One shared counter: quiet time in DIRTY, wait time in SAVING, gap in HOLDOFF
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pending;
        w_count_nxt = r_save_count;
        w_terr_nxt  = r_timeout_err;
        if (!arm) begin
            w_state_nxt = DISARMED;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                DISARMED: begin
                    w_state_nxt = CLEAN;
                    w_cnt_nxt   = '0;
                end
                CLEAN: begin
                    if (w_hit) begin
                        w_state_nxt = DIRTY;
                        w_cnt_nxt   = '0;
                    end
                end
                DIRTY: begin
                    if (w_hit) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == QUIET_LAST) begin
                        w_state_nxt = SAVING;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end
                SAVING: begin
                    if (w_hit) w_pend_nxt = 1'b1;
                    // done wins over a coincident timeout
                    if (save_done) begin
                        w_state_nxt = HOLDOFF;
                        w_cnt_nxt   = '0;
                        w_count_nxt = r_save_count + 8'd1;
                        w_terr_nxt  = 1'b0;
                    end else if (r_cnt == TMO_LAST) begin
                        w_state_nxt = HOLDOFF;
                        w_cnt_nxt   = '0;
                        w_terr_nxt  = 1'b1;
                        w_pend_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end
                HOLDOFF: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = (r_pending || w_hit) ? DIRTY : CLEAN;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                        if (w_hit) w_pend_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = DISARMED;
                    w_cnt_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= DISARMED;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_save_count  <= '0;
            r_timeout_err <= 1'b0;
            r_valid       <= 1'b0;
            r_dirty       <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pending     <= w_pend_nxt;
            r_save_count  <= w_count_nxt;
            r_timeout_err <= w_terr_nxt;
            r_valid       <= (w_state_nxt == SAVING);
            r_dirty       <= (w_state_nxt == DIRTY) || (w_state_nxt == SAVING) || w_pend_nxt;
`ifdef HS_SAVE_HALT_EN
            r_halt        <= (w_state_nxt == SAVING);
`else
            r_halt        <= 1'b0;
`endif
        end
    end

    assign save_valid       = r_valid;
    assign dirty            = r_dirty;
    assign save_count       = r_save_count;
    assign timeout_err      = r_timeout_err;
    assign processor_halt   = r_halt;
    assign save_slot_id     = SLOT_ID;
    assign save_bridge_addr = BRIDGE_ADDR;
    assign save_length      = {20'd0, WIN_LEN};

endmodule

// File: tb/tb_hs_save_scheduler.sv
// Randomized and directed bench for hs_save_scheduler against a countdown-based
// behavioural model of the save policy.
module tb_hs_save_scheduler;

    localparam int QUIET = 16;
    localparam int HOLD  = 20;
    localparam int TMO   = 32;
    localparam int BASE  = 'h620;
    localparam int LEN   = 'h050;

    localparam int M_OFF  = 0;
    localparam int M_IDLE = 1;
    localparam int M_WAIT = 2;
    localparam int M_SAVE = 3;
    localparam int M_HOLD = 4;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        cpu_wr;
    logic [11:0] cpu_addr;
    logic        save_valid;
    logic [15:0] save_slot_id;
    logic [31:0] save_bridge_addr;
    logic [31:0] save_length;
    logic        save_done;
    logic        dirty;
    logic [7:0]  save_count;
    logic        timeout_err;
    logic        processor_halt;

    int n_checks;
    int n_errors;

    int m_mode;
    int m_quiet_left;
    int m_save_left;
    int m_hold_left;
    bit m_pending;
    int m_count;
    bit m_terr;

    hs_save_scheduler #(
        .QUIET_CYCLES   (24'd16),
        .HOLDOFF_CYCLES (24'd20),
        .TIMEOUT_CYCLES (24'd32)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .arm              (arm),
        .cpu_wr           (cpu_wr),
        .cpu_addr         (cpu_addr),
        .save_valid       (save_valid),
        .save_slot_id     (save_slot_id),
        .save_bridge_addr (save_bridge_addr),
        .save_length      (save_length),
        .save_done        (save_done),
        .dirty            (dirty),
        .save_count       (save_count),
        .timeout_err      (timeout_err),
        .processor_halt   (processor_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Policy model: counts remaining cycles down instead of elapsed cycles up
    task automatic model_step();
        bit hit;
        hit = cpu_wr && (int'(cpu_addr) >= BASE) && (int'(cpu_addr) < BASE + LEN);
        if (!reset_n) begin
            m_mode = M_OFF; m_pending = 0; m_count = 0; m_terr = 0;
        end else if (!arm) begin
            m_mode = M_OFF; m_pending = 0;
        end else begin
            case (m_mode)
                M_OFF:  m_mode = M_IDLE;
                M_IDLE: if (hit) begin m_mode = M_WAIT; m_quiet_left = QUIET; end
                M_WAIT: begin
                    if (hit) m_quiet_left = QUIET;
                    else begin
                        m_quiet_left--;
                        if (m_quiet_left == 0) begin m_mode = M_SAVE; m_save_left = TMO; end
                    end
                end
                M_SAVE: begin
                    if (hit) m_pending = 1;
                    if (save_done) begin
                        m_count = (m_count + 1) % 256; m_terr = 0;
                        m_mode = M_HOLD; m_hold_left = HOLD;
                    end else begin
                        m_save_left--;
                        if (m_save_left == 0) begin
                            m_terr = 1; m_pending = 1; m_mode = M_HOLD; m_hold_left = HOLD;
                        end
                    end
                end
                default: begin
                    if (hit) m_pending = 1;
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        if (m_pending) begin m_mode = M_WAIT; m_quiet_left = QUIET; m_pending = 0; end
                        else m_mode = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        bit exp_valid;
        bit exp_halt;
        exp_valid = (m_mode == M_SAVE);
`ifdef HS_SAVE_HALT_EN
        exp_halt = exp_valid;
`else
        exp_halt = 1'b0;
`endif
        chk_eq("save_valid", save_valid, exp_valid);
        chk_eq("dirty", dirty, (m_mode == M_WAIT) || (m_mode == M_SAVE) || m_pending);
        chk_eq("save_count", save_count, m_count);
        chk_eq("timeout_err", timeout_err, m_terr);
        chk_eq("processor_halt", processor_halt, exp_halt);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        cpu_wr = 0; save_done = 0;
        repeat (n) cyc();
    endtask

    task automatic hit_at(input logic [11:0] a);
        cpu_wr = 1; cpu_addr = a;
        cyc();
        cpu_wr = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!save_valid && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk_eq("wait_valid_timeout", 0, 1);
    endtask

    task automatic pulse_done();
        save_done = 1;
        cyc();
        save_done = 0;
    endtask

    initial begin
        int n;
        int c0;
        bit seen;
        n_checks = 0; n_errors = 0;
        m_mode = M_OFF; m_pending = 0; m_count = 0; m_terr = 0;
        m_quiet_left = 0; m_save_left = 0; m_hold_left = 0;
        reset_n = 0; arm = 0; cpu_wr = 0; cpu_addr = '0; save_done = 0;
        @(negedge clk);
        cyc(); cyc();
        chk_eq("rst_valid", save_valid, 0);
        chk_eq("rst_dirty", dirty, 0);
        chk_eq("rst_count", save_count, 0);
        chk_eq("rst_terr", timeout_err, 0);
        chk_eq("rst_halt", processor_halt, 0);
        chk_eq("slot_id", save_slot_id, 32'd2);
        chk_eq("bridge_addr", save_bridge_addr, 32'h10001620);
        chk_eq("length", save_length, 32'h50);

        reset_n = 1;
        hit_at(12'h620);
        chk_eq("disarmed_ignores_hit", dirty, 0);
        arm = 1;
        cyc();

        // basic save with latency
        hit_at(12'h620);
        chk_eq("hit_dirty", dirty, 1);
        wait_valid(n);
        chk_eq("quiet_latency", n, 16);
        pulse_done();
        chk_eq("first_count", save_count, 1);
        chk_eq("first_dirty", dirty, 0);
        idle(22);

        // window edges
        hit_at(12'h61F);
        chk_eq("below_window", dirty, 0);
        hit_at(12'h670);
        chk_eq("above_window", dirty, 0);
        hit_at(12'h66F);
        chk_eq("last_byte", dirty, 1);
        wait_valid(n);
        pulse_done();
        idle(22);

        // steady writes keep postponing the save
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            hit_at(12'h620 + 12'(k));
            for (int j = 0; j < 9; j++) begin
                cyc();
                if (save_valid) seen = 1;
            end
        end
        chk_eq("storm_no_save", seen, 0);
        wait_valid(n);
        chk_eq("storm_tail", n, 7);
        pulse_done();
        idle(22);

        // hit while saving forces a second save after holdoff
        c0 = save_count;
        hit_at(12'h630);
        wait_valid(n);
        hit_at(12'h640);
        pulse_done();
        chk_eq("resave_count1", save_count, (c0 + 1) % 256);
        chk_eq("pending_dirty", dirty, 1);
        idle(20);
        wait_valid(n);
        chk_eq("resave_latency", n, 16);
        pulse_done();
        chk_eq("resave_count2", save_count, (c0 + 2) % 256);
        idle(22);

        // timeout then retry
        hit_at(12'h650);
        wait_valid(n);
        idle(31);
        chk_eq("pre_timeout_valid", save_valid, 1);
        chk_eq("pre_timeout_terr", timeout_err, 0);
        cyc();
        chk_eq("timeout_terr", timeout_err, 1);
        chk_eq("timeout_valid", save_valid, 0);
        chk_eq("timeout_pending", dirty, 1);
        idle(20);
        wait_valid(n);
        chk_eq("retry_latency", n, 16);
        pulse_done();
        chk_eq("retry_clears_terr", timeout_err, 0);
        idle(22);

        // abort mid-save by arm and by reset
        hit_at(12'h620);
        wait_valid(n);
        c0 = save_count;
        arm = 0;
        cyc();
        chk_eq("arm_drop_valid", save_valid, 0);
        chk_eq("arm_drop_count", save_count, c0);
        arm = 1;
        cyc();
        hit_at(12'h620);
        wait_valid(n);
        reset_n = 0;
        cyc();
        chk_eq("reset_drop_valid", save_valid, 0);
        chk_eq("reset_count", save_count, 0);
        reset_n = 1;
        cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 299) == 0) arm = ~arm;
            cpu_wr    = ($urandom_range(0, 29) == 0);
            cpu_addr  = 12'($urandom_range('h600, 'h690));
            save_done = ($urandom_range(0, 24) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
